// File: rtl/fp16_div_seq.sv
// Sequential IEEE-754 binary16 divider (a_operand / b_operand).
// Restoring division produces one quotient bit per cycle. A single round
// cycle then applies round-to-nearest-even. Subnormal inputs are treated as
// zero, and subnormal results are flushed to signed zero.
// Valid/ready handshakes are used on both the operand side and the result side.
module fp16_div_seq #(
   parameter int DWIDTH = 16,
   parameter int EWIDTH = 5,
   parameter int MWIDTH = 10,
   parameter int BIAS   = 15
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DWIDTH-1:0] a_operand,
   input  logic [DWIDTH-1:0] b_operand,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DWIDTH-1:0] result,
   output logic              Exception,
   output logic              Overflow,
   output logic              Underflow,
   output logic              DivByZero
);

   localparam int SW  = MWIDTH + 1;   // significand width including hidden bit
   localparam int RW  = MWIDTH + 2;   // partial remainder width
   localparam int QW  = MWIDTH + 3;   // quotient width (11 bits + guard + 1)
   localparam int EXW = EWIDTH + 2;   // signed working exponent width
   localparam int CW  = 4;

   localparam logic [DWIDTH-1:0]    QNAN     = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(MWIDTH-1){1'b0}}};
   localparam logic signed [EXW-1:0] E_MAX   = EXW'((1 << EWIDTH) - 1);
   localparam logic signed [EXW-1:0] E_ONE   = EXW'(1);
   localparam logic signed [EXW-1:0] E_BIAS  = EXW'(BIAS);
   localparam logic [CW-1:0]         CNT_END = CW'(QW - 1);

   typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
   state_t state, state_next;

   // Operand field decode
   logic              sa, sb, s_in;
   logic [EWIDTH-1:0] ea_f, eb_f;
   logic [MWIDTH-1:0] fa, fb;
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic              accept;

   assign sa     = a_operand[DWIDTH-1];
   assign sb     = b_operand[DWIDTH-1];
   assign s_in   = sa ^ sb;
   assign ea_f   = a_operand[DWIDTH-2 -: EWIDTH];
   assign eb_f   = b_operand[DWIDTH-2 -: EWIDTH];
   assign fa     = a_operand[MWIDTH-1:0];
   assign fb     = b_operand[MWIDTH-1:0];
   assign a_zero = (ea_f == '0);
   assign b_zero = (eb_f == '0);
   assign a_nan  = (ea_f == '1) &  (|fa);
   assign b_nan  = (eb_f == '1) &  (|fb);
   assign a_inf  = (ea_f == '1) & ~(|fa);
   assign b_inf  = (eb_f == '1) & ~(|fb);
   assign accept = in_valid & in_ready;

   // Datapath registers
   logic              sign;
   logic [EWIDTH-1:0] ea, eb;
   logic [SW-1:0]     mb;
   logic [RW-1:0]     rem;
   logic [QW-1:0]     q;
   logic [CW-1:0]     cnt;

   // Special-operand resolution, evaluated on the accept cycle
   logic              special, sp_exc, sp_dbz;
   logic [DWIDTH-1:0] sp_result;

   // Classify operands; anything not special goes through the divider
   always_comb begin
      special   = 1'b1;
      sp_exc    = 1'b0;
      sp_dbz    = 1'b0;
      sp_result = '0;
      if (a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero)) begin
         sp_result = QNAN;
         sp_exc    = 1'b1;
      end else if (a_inf) begin
         sp_result = {s_in, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
         sp_exc    = 1'b1;
      end else if (b_inf) begin
         sp_result = {s_in, {(DWIDTH-1){1'b0}}};
         sp_exc    = 1'b1;
      end else if (b_zero) begin
         sp_result = {s_in, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
         sp_dbz    = 1'b1;
      end else if (a_zero) begin
         sp_result = {s_in, {(DWIDTH-1){1'b0}}};
      end else begin
         special   = 1'b0;
      end
   end

   // One restoring-division step: compare, conditionally subtract, shift
   logic          q_bit;
   logic [RW-1:0] rem_sub, rem_next;

   always_comb begin
      q_bit    = (rem >= {1'b0, mb});
      rem_sub  = q_bit ? (rem - {1'b0, mb}) : rem;
      rem_next = {rem_sub[RW-2:0], 1'b0};
   end

   // Normalise the quotient, round to nearest-even, then range-check the exponent
   logic signed [EXW-1:0] e_base, e_raw, e_fin;
   logic [MWIDTH-1:0]     frac_raw;
   logic [MWIDTH:0]       frac_inc;
   logic                  guard, sticky, rnd_up, rnd_ovf, rnd_unf;
   logic [DWIDTH-1:0]     rnd_result;

   always_comb begin
      e_base = EXW'(ea) - EXW'(eb) + E_BIAS;
      if (q[QW-1]) begin
         frac_raw = q[QW-2:2];
         guard    = q[1];
         sticky   = q[0] | (|rem);
         e_raw    = e_base;
      end else begin
         frac_raw = q[QW-3:1];
         guard    = q[0];
         sticky   = |rem;
         e_raw    = e_base - E_ONE;
      end
      rnd_up   = guard & (sticky | frac_raw[0]);
      // A carry out of the fraction means the significand reached 2.0;
      // the fraction bits are then already zero, so only the exponent moves.
      frac_inc = {1'b0, frac_raw} + {{MWIDTH{1'b0}}, rnd_up};
      e_fin    = e_raw + EXW'(frac_inc[MWIDTH]);
      rnd_ovf  = (e_fin >= E_MAX);
      rnd_unf  = (e_fin < E_ONE);
      if (rnd_ovf)
         rnd_result = {sign, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
      else if (rnd_unf)
         rnd_result = {sign, {(DWIDTH-1){1'b0}}};
      else
         rnd_result = {sign, e_fin[EWIDTH-1:0], frac_inc[MWIDTH-1:0]};
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (accept) state_next = special ? DONE : DIV;
         DIV:   if (cnt == CNT_END) state_next = ROUND;
         ROUND: state_next = DONE;
         DONE:  if (out_valid & out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM output decode
   always_comb begin
      in_ready = (state == IDLE);
   end

   // Operand capture, division iterations, result/flag registers and out_valid
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sign      <= 1'b0;
         ea        <= '0;
         eb        <= '0;
         mb        <= '0;
         rem       <= '0;
         q         <= '0;
         cnt       <= '0;
         result    <= '0;
         Exception <= 1'b0;
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
         DivByZero <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sign <= s_in;
                  ea   <= ea_f;
                  eb   <= eb_f;
                  mb   <= {1'b1, fb};
                  rem  <= {1'b0, 1'b1, fa};
                  q    <= '0;
                  cnt  <= '0;
                  if (special) begin
                     result    <= sp_result;
                     Exception <= sp_exc;
                     Overflow  <= 1'b0;
                     Underflow <= 1'b0;
                     DivByZero <= sp_dbz;
                  end
               end
            end
            DIV: begin
               rem <= rem_next;
               q   <= {q[QW-2:0], q_bit};
               cnt <= cnt + CW'(1);
            end
            ROUND: begin
               result    <= rnd_result;
               Exception <= 1'b0;
               Overflow  <= rnd_ovf;
               Underflow <= rnd_unf;
               DivByZero <= 1'b0;
            end
            DONE: begin
               // out_valid is raised one cycle after entering DONE and
               // dropped on the handshake edge that returns the FSM to IDLE.
               if (!out_valid)
                  out_valid <= 1'b1;
               else if (out_ready)
                  out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_div_seq.sv
// Self-checking bench for fp16_div_seq: table of operand pairs with expected
// result, flags {Exception,Overflow,Underflow,DivByZero} and latency, checked
// through a scoreboard queue, plus backpressure and mid-operation reset sequences.
module tb_fp16_div_seq;

   logic        clk = 1'b0;
   logic        rstn, in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a_operand, b_operand, result;
   logic        exception, overflow, underflow, div_by_zero;

   always #5 clk = ~clk;

   fp16_div_seq dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_operand (a_operand),
      .b_operand (b_operand),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .Exception (exception),
      .Overflow  (overflow),
      .Underflow (underflow),
      .DivByZero (div_by_zero)
   );

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [3:0]  flags;
      int          lat;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic [3:0]  flags;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Pop the oldest expected result and compare it with the DUT outputs
   task automatic score(input string name);
      exp_t e;
      check({name, "_sb_depth"}, exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({name, "_result"}, {16'h0, result}, {16'h0, e.res});
         check({name, "_flags"}, {28'h0, exception, overflow, underflow, div_by_zero},
               {28'h0, e.flags});
      end
   endtask

   // Wait (bounded) until out_valid, counting clock edges; cyc is updated in place
   task automatic wait_valid(inout int cyc);
      while (!out_valid && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [3:0] flg, input int lat);
      int cyc;
      @(negedge clk);
      a_operand = a;
      b_operand = b;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_in_ready"}, {31'h0, in_ready}, 32'h1);
      @(posedge clk);
      exp_q.push_back('{res, flg});
      #1;
      in_valid = 1'b0;
      cyc = 0;
      wait_valid(cyc);
      check({name, "_out_valid"}, {31'h0, out_valid}, 32'h1);
      check({name, "_latency"}, cyc, lat);
      score(name);
      $display("txn %s a=%h b=%h result=%h flags=%b lat=%0d", name, a, b, result,
               {exception, overflow, underflow, div_by_zero}, cyc);
      @(posedge clk);
      #1;
      check({name, "_post_valid"}, {31'h0, out_valid}, 32'h0);
      check({name, "_post_ready"}, {31'h0, in_ready}, 32'h1);
   endtask

   initial begin
      int cyc;
      int bad;

      //            name          a         b         result    flags  lat
      vecs.push_back('{"exact",     16'h4200, 16'h3E00, 16'h4000, 4'b0000, 15});
      vecs.push_back('{"rne_pos",   16'h3C00, 16'h4200, 16'h3555, 4'b0000, 15});
      vecs.push_back('{"rne_neg",   16'hBC00, 16'h4200, 16'hB555, 4'b0000, 15});
      vecs.push_back('{"rnd_up",    16'h3E00, 16'h3D00, 16'h3CCD, 4'b0000, 15});
      vecs.push_back('{"lt_one",    16'h3C00, 16'h3E00, 16'h3955, 4'b0000, 15});
      vecs.push_back('{"neg_neg",   16'hC200, 16'hBE00, 16'h4000, 4'b0000, 15});
      vecs.push_back('{"min_norm",  16'h0400, 16'h3C00, 16'h0400, 4'b0000, 15});
      vecs.push_back('{"max_norm",  16'h7BFF, 16'h3C00, 16'h7BFF, 4'b0000, 15});
      vecs.push_back('{"overflow",  16'h7BFF, 16'h1400, 16'h7C00, 4'b0100, 15});
      vecs.push_back('{"underflow", 16'h0400, 16'h4000, 16'h0000, 4'b0010, 15});
      vecs.push_back('{"div0",      16'h3C00, 16'h0000, 16'h7C00, 4'b0001, 1});
      vecs.push_back('{"div0_neg",  16'hBC00, 16'h0000, 16'hFC00, 4'b0001, 1});
      vecs.push_back('{"zero_zero", 16'h0000, 16'h0000, 16'h7E00, 4'b1000, 1});
      vecs.push_back('{"inf_fin",   16'h7C00, 16'h4000, 16'h7C00, 4'b1000, 1});
      vecs.push_back('{"inf_neg",   16'h7C00, 16'hC000, 16'hFC00, 4'b1000, 1});
      vecs.push_back('{"nan_a",     16'h7E00, 16'h3C00, 16'h7E00, 4'b1000, 1});
      vecs.push_back('{"inf_inf",   16'h7C00, 16'h7C00, 16'h7E00, 4'b1000, 1});
      vecs.push_back('{"fin_inf",   16'hBC00, 16'h7C00, 16'h8000, 4'b1000, 1});
      vecs.push_back('{"zero_fin",  16'h0000, 16'h3C00, 16'h0000, 4'b0000, 1});

      rstn      = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_operand = '0;
      b_operand = '0;
      #2 rstn = 1'b0;
      #10;
      check("reset_in_ready", {31'h0, in_ready}, 32'h1);
      check("reset_out_valid", {31'h0, out_valid}, 32'h0);
      check("reset_result", {16'h0, result}, 32'h0);
      check("reset_flags", {28'h0, exception, overflow, underflow, div_by_zero}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags, vecs[i].lat);

      // Backpressure, with operands changed while busy (must be ignored)
      @(negedge clk);
      a_operand = 16'h4200;
      b_operand = 16'h3E00;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      exp_q.push_back('{16'h4000, 4'b0000});
      #1;
      a_operand = 16'h0000;
      b_operand = 16'h0000;
      repeat (4) @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc = 4;
      wait_valid(cyc);
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      check("bp_latency", cyc, 15);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold_result", {16'h0, result}, 32'h4000);
         check("bp_hold_valid", {31'h0, out_valid}, 32'h1);
         check("bp_hold_in_ready", {31'h0, in_ready}, 32'h0);
      end
      score("bp");
      $display("txn bp a=4200 b=3e00 result=%h flags=%b held=10", result,
               {exception, overflow, underflow, div_by_zero});
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", {31'h0, out_valid}, 32'h0);
      check("bp_release_in_ready", {31'h0, in_ready}, 32'h1);
      run_op("bp_second", 16'h3C00, 16'h4200, 16'h3555, 4'b0000, 15);

      // Reset five cycles into DIV aborts the operation
      @(negedge clk);
      a_operand = 16'h4200;
      b_operand = 16'h3E00;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check("mid_busy_in_ready", {31'h0, in_ready}, 32'h0);
      rstn = 1'b0;
      #1;
      check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
      check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
      @(negedge clk);
      rstn = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) bad++;
      end
      check("mid_rst_no_pending", bad, 0);
      $display("txn reset_mid_op aborted stray_valid_cycles=%0d", bad);
      run_op("after_reset", 16'h4200, 16'h3E00, 16'h4000, 4'b0000, 15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
